imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200).
REQ-002 Parameter MAX_WORDS, default 256, instruction memory capacity in 32-bit words.
REQ-003 Port clk  input  1  single system clock; every register in the block is clocked on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port uart_rx  input  1  asynchronous serial line; idles high.
REQ-006 Port load_req  input  1  synchronous pulse that starts a load session.
REQ-007 Port imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-008 Port imem_addr  output  32  byte address of the write; always word-aligned.
REQ-009 Port imem_wdata  output  32  write data.
REQ-010 Port core_rst  output  1  holds the pipelined core in reset while high.
REQ-011 Port busy  output  1  high while a load session is in progress.
REQ-012 Port done  output  1  one-cycle pulse when a load completes successfully.
REQ-013 Port err  output  1  sticky error flag; cleared by the next load_req or by rst.

Function
REQ-014 UART receive: uart_rx SHALL pass through a 2-FF synchronizer before any use.
REQ-015 UART framing: the block SHALL detect the start bit on a falling edge and re-check it at CLKS_PER_BIT/2; a high level at that sample is a false start and SHALL be discarded.
REQ-016 UART data: the block SHALL sample 8 data bits, LSB first, at mid-bit, then 1 stop bit.
REQ-017 Stop bit: a stop bit sampled low SHALL be treated as a framing error.
REQ-018 Frame format: 2-byte little-endian word count N, followed by 4*N payload bytes; each word is assembled little-endian.
REQ-019 States: IDLE, HDR0, HDR1, DATA, DONE (plus CHK when checksum support is compiled in, see REQ-034).
REQ-020 IDLE -> HDR0 on load_req; on that entry the block SHALL clear err, set busy=1, set core_rst=1 and set the address counter to 0.
REQ-021 load_req SHALL be ignored in every state other than IDLE.
REQ-022 Header bytes SHALL be latched in HDR0 and then HDR1; after HDR1 the block SHALL go to DATA if N>0, or to DONE if N=0.
REQ-023 N > MAX_WORDS SHALL set err and return the block to IDLE with no writes; core_rst SHALL stay 1.
REQ-024 Word write: exactly one clk cycle after the 4th byte of a word completes (stop bit sampled), the block SHALL assert imem_we=1 for exactly one cycle, with imem_addr = 4*k and imem_wdata = that word.
REQ-025 After each write, imem_addr SHALL advance by 4; the state SHALL move from DATA to DONE after word N-1 is written.
REQ-026 Any framing error during HDR0, HDR1 or DATA SHALL set err and return the block to IDLE; words already written are not rolled back; core_rst SHALL stay 1.
REQ-027 DONE SHALL last one cycle: done=1, busy->0, core_rst->0, then the block returns to IDLE.
REQ-028 core_rst SHALL change only on successful completion (->0) or on load_req acceptance (->1).
REQ-029 imem_we and done SHALL never be high in the same cycle.

Reset
REQ-030 On rst the block SHALL asynchronously enter IDLE and drive: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, err=0.
REQ-031 On rst the UART receiver SHALL return to idle, discarding any partial byte.
REQ-032 Assertion of rst mid-session SHALL abort the session and suppress all further writes.

Configuration
REQ-033 Macro IMEM_LOADER_CHECKSUM_EN SHALL select whether checksum support is compiled in.
REQ-034 With IMEM_LOADER_CHECKSUM_EN defined: one trailing byte follows the payload and is received in state CHK; it must equal the XOR of all header and payload bytes; a match goes to DONE, a mismatch sets err, goes to IDLE and keeps core_rst=1.
REQ-035 With IMEM_LOADER_CHECKSUM_EN undefined: there is no trailing byte; the block goes from DATA (or from HDR1 when N=0) directly to DONE.

Structure
REQ-036 Package imem_loader_pkg SHALL hold the state encoding, the default CLKS_PER_BIT value and the header length constant (2).
REQ-037 The UART byte receiver SHALL be a separate sub-module uart_rx_byte with outputs byte_valid (1-cycle pulse), byte_data[7:0] and frame_err.

Verification (CLKS_PER_BIT=4, MAX_WORDS=8)
REQ-038 Load of N=2 with words 0x00000013 and 0xDEADBEEF -> writes 0x00000013 at addr 0x0 and 0xDEADBEEF at addr 0x4; done pulse; core_rst falls; err=0.
REQ-039 Load of N=0 -> no imem_we; done pulse; core_rst=0.
REQ-040 Load of N=9 -> err=1; zero writes; core_rst=1; busy=0.
REQ-041 Stop bit forced low in payload byte 5 of an N=2 load -> exactly one write (addr 0x0); err=1; state IDLE.
REQ-042 rst asserted after 3 payload bytes -> all outputs at reset values immediately; a subsequent N=1 load of 0x12345678 writes 0x12345678 at addr 0x0.
REQ-043 With IMEM_LOADER_CHECKSUM_EN: correct XOR byte -> done; checksum byte corrupted by 0x01 -> err=1, core_rst=1. Also: a 1-cycle low glitch on uart_rx -> no byte is received.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// The CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned HDR_BYTES            = 2;
  localparam int unsigned BYTES_PER_WORD       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , ST_CHK
`endif
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling, false-start
// rejection and stop-bit framing check. All outputs are registered pulses/data.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned HALF_M1 = (CLKS_PER_BIT >= 2) ? (CLKS_PER_BIT / 2) - 1 : 0;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_M1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync2_q, prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Bit timing: start re-checked at half a bit, data/stop sampled every full bit after.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d  = '0;
          data_d = {sync2_q, data_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a little-endian word image from UART into instruction memory while
// holding the core in reset. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned MAX_WORDS    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic        load_req,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_TAIL = ST_CHK;
`else
  localparam state_e ST_TAIL = ST_DONE;
`endif

  logic        rx_valid, rx_ferr;
  logic [7:0]  rx_data;
  logic [15:0] hdr_n;

  state_e      state_q;
  logic [15:0] n_q, word_cnt_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] word_q;
  logic        we_q, core_rst_q, busy_q, done_q, err_q;
  logic [31:0] addr_q, wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .frame_err (rx_ferr)
  );

  assign hdr_n = {rx_data, n_q[7:0]};

  // Session FSM; every abort path keeps core_rst asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (we_q) begin
        addr_q <= addr_q + 32'd4;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (rx_valid) begin
        csum_q <= csum_q ^ rx_data;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            core_rst_q <= 1'b1;
            addr_q     <= '0;
            state_q    <= ST_HDR0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        ST_HDR0: begin
          if (rx_ferr) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            n_q[7:0] <= rx_data;
            state_q  <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (rx_ferr) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            n_q        <= hdr_n;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            if (32'(hdr_n) > MAX_WORDS) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else if (hdr_n == 16'd0) begin
              state_q <= ST_TAIL;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_ferr) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              we_q       <= 1'b1;
              wdata_q    <= {rx_data, word_q};
              word_cnt_q <= word_cnt_q + 16'd1;
              if (word_cnt_q == n_q - 16'd1) begin
                state_q <= ST_TAIL;
              end
            end else begin
              word_q <= {rx_data, word_q[23:8]};
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (rx_ferr) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (rx_valid) begin
            if (rx_data == csum_q) begin
              state_q <= ST_DONE;
            end else begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
`endif
        ST_DONE: begin
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          core_rst_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = core_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: serialises frames onto uart_rx and
// compares observed writes/flags with a frame-level expectation model.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int unsigned CPB  = 4;
  localparam int unsigned MAXW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        load_req;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS   (MAXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .load_req  (load_req),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt;
  int          overlap_cnt;
  int          long_we_cnt;
  logic        prev_we = 1'b0;

  logic [31:0] words[16];
  int          exp_nw;
  bit          exp_ok;

  // Observe DUT activity away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (done === 1'b1) done_cnt++;
    if (imem_we === 1'b1 && done === 1'b1) overlap_cnt++;
    if (imem_we === 1'b1 && prev_we === 1'b1) long_we_cnt++;
    prev_we = imem_we;
  end

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt    = 0;
    overlap_cnt = 0;
    long_we_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = !bad_stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    if (bad_stop) repeat (2 * CPB) @(negedge clk);
  endtask

  // Drives one whole session and derives the expected outcome from the frame rules.
  task automatic run_load(input int n, input int bad_pay, input bit bad_chk,
                          input int mid_req_at, input bit glitch);
    logic [7:0]  fr[$];
    logic [7:0]  x;
    logic [15:0] nn;
    int          limit;
    nn = 16'(n);
    fr.push_back(nn[7:0]);
    fr.push_back(nn[15:8]);
    if (n <= int'(MAXW)) begin
      for (int w = 0; w < n; w++)
        for (int b = 0; b < 4; b++) fr.push_back(8'(words[w] >> (8 * b)));
    end
    x = 8'h00;
    foreach (fr[i]) x = x ^ fr[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (n <= int'(MAXW)) fr.push_back(x ^ (bad_chk ? 8'h01 : 8'h00));
`endif
    limit = (bad_pay >= 0) ? 2 + bad_pay + 1 : fr.size();
    exp_nw = (n > int'(MAXW)) ? 0 : ((bad_pay >= 0) ? bad_pay / 4 : n);
    exp_ok = (n <= int'(MAXW)) && (bad_pay < 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_ok = exp_ok && !bad_chk;
`endif
    clear_obs();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || core_rst !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b core_rst=%b err=%b, required 1 1 0", busy, core_rst, err);
    end
    if (glitch) begin
      uart_rx = 1'b0;
      @(negedge clk) uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
    end
    for (int i = 0; i < limit; i++) begin
      if (i == mid_req_at) begin
        load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
      end
      send_byte(fr[i], (bad_pay >= 0) && (i == limit - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_rx = 1'b1; load_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_we !== 1'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0 || core_rst !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset: we=%b addr=%h wdata=%h core_rst=%b busy=%b done=%b err=%b, required 0 0 0 1 0 0 0",
               imem_we, imem_addr, imem_wdata, core_rst, busy, done, err);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_two_words();
    words[0] = 32'h0000_0013;
    words[1] = 32'hDEAD_BEEF;
    run_load(2, -1, 1'b0, -1, 1'b0);
    checks++;
    if (wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL two_words_count: got %0d writes, required 2", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h0000_0013) begin
        errors++;
        $display("FAIL two_words_w0: got %h@%h, required 00000013@00000000", wr_data_q[0], wr_addr_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 32'h4 || wr_data_q[1] !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL two_words_w1: got %h@%h, required deadbeef@00000004", wr_data_q[1], wr_addr_q[1]);
      end
    end
    checks++;
    if (done_cnt != 1 || core_rst !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL two_words_flags: done_cnt=%0d core_rst=%b err=%b busy=%b, required 1 0 0 0",
               done_cnt, core_rst, err, busy);
    end
  endtask

  task automatic test_zero_words();
    run_load(0, -1, 1'b0, -1, 1'b0);
    checks++;
    if (wr_addr_q.size() != 0 || done_cnt != 1 || core_rst !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL zero_words: writes=%0d done_cnt=%0d core_rst=%b err=%b, required 0 1 0 0",
               wr_addr_q.size(), done_cnt, core_rst, err);
    end
  endtask

  task automatic test_overflow();
    run_load(9, -1, 1'b0, -1, 1'b0);
    checks++;
    if (wr_addr_q.size() != 0 || done_cnt != 0 || err !== 1'b1 || core_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow: writes=%0d done_cnt=%0d err=%b core_rst=%b busy=%b, required 0 0 1 1 0",
               wr_addr_q.size(), done_cnt, err, core_rst, busy);
    end
  endtask

  task automatic test_frame_err();
    words[0] = $urandom;
    words[1] = $urandom;
    run_load(2, 4, 1'b0, -1, 1'b0);
    checks++;
    if (wr_addr_q.size() != 1) begin
      errors++;
      $display("FAIL frame_err_count: got %0d writes, required 1", wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== words[0]) begin
        errors++;
        $display("FAIL frame_err_w0: got %h@%h, required %h@00000000", wr_data_q[0], wr_addr_q[0], words[0]);
      end
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b1 || done_cnt != 0) begin
      errors++;
      $display("FAIL frame_err_flags: err=%b busy=%b core_rst=%b done_cnt=%0d, required 1 0 1 0",
               err, busy, core_rst, done_cnt);
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] hdr[6];
    hdr[0] = 8'h02; hdr[1] = 8'h00; hdr[2] = 8'hA1; hdr[3] = 8'hB2; hdr[4] = 8'hC3; hdr[5] = 8'h5A;
    clear_obs();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(hdr[i], 1'b0);
    // Partial fourth payload byte, then reset in the middle of it.
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = hdr[5][i];
      repeat (CPB) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_we !== 1'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0 || core_rst !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: we=%b addr=%h wdata=%h core_rst=%b busy=%b done=%b err=%b, required 0 0 0 1 0 0 0",
               imem_we, imem_addr, imem_wdata, core_rst, busy, done, err);
    end
    checks++;
    if (wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_nowrite: got %0d writes, required 0", wr_addr_q.size());
    end
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    words[0] = 32'h1234_5678;
    run_load(1, -1, 1'b0, -1, 1'b0);
    checks++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h1234_5678 || done_cnt != 1) begin
      errors++;
      $display("FAIL rst_mid_reload: writes=%0d first=%h@%h done_cnt=%0d, required 1 12345678@00000000 1",
               wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0,
               (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'h0, done_cnt);
    end
  endtask

  task automatic test_glitch();
    words[0] = 32'hCAFE_F00D;
    run_load(1, -1, 1'b0, -1, 1'b1);
    checks++;
    if (wr_addr_q.size() != 1 || wr_data_q[0] !== 32'hCAFE_F00D || done_cnt != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL glitch: writes=%0d data=%h done_cnt=%0d err=%b, required 1 cafef00d 1 0",
               wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0, done_cnt, err);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int n;
      n = $urandom_range(1, MAXW);
      for (int k = 0; k < n; k++) words[k] = $urandom;
      run_load(n, -1, 1'b0, $urandom_range(2, 5), 1'b0);
      checks++;
      if (wr_addr_q.size() != exp_nw) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d writes, required %0d", it, wr_addr_q.size(), exp_nw);
      end else begin
        for (int k = 0; k < exp_nw; k++) begin
          checks++;
          if (wr_addr_q[k] !== 32'(4 * k) || wr_data_q[k] !== words[k]) begin
            errors++;
            $display("FAIL rand%0d_w%0d: got %h@%h, required %h@%h", it, k, wr_data_q[k], wr_addr_q[k],
                     words[k], 32'(4 * k));
          end
        end
      end
      checks++;
      if (done_cnt != (exp_ok ? 1 : 0) || err !== !exp_ok || core_rst !== !exp_ok || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_flags: done_cnt=%0d err=%b core_rst=%b busy=%b, required ok=%0d", it,
                 done_cnt, err, core_rst, busy, exp_ok);
      end
      checks++;
      if (overlap_cnt != 0 || long_we_cnt != 0) begin
        errors++;
        $display("FAIL rand%0d_strobes: we&done=%0d we_long=%0d, required 0 0", it, overlap_cnt, long_we_cnt);
      end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    words[0] = $urandom;
    words[1] = $urandom;
    run_load(2, -1, 1'b0, -1, 1'b0);
    checks++;
    if (wr_addr_q.size() != 2 || done_cnt != 1 || err !== 1'b0 || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL chk_good: writes=%0d done_cnt=%0d err=%b core_rst=%b, required 2 1 0 0",
               wr_addr_q.size(), done_cnt, err, core_rst);
    end
    run_load(2, -1, 1'b1, -1, 1'b0);
    checks++;
    if (done_cnt != 0 || err !== 1'b1 || core_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL chk_bad: done_cnt=%0d err=%b core_rst=%b busy=%b, required 0 1 1 0",
               done_cnt, err, core_rst, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_words();
    test_overflow();
    test_frame_err();
    test_rst_mid();
    test_glitch();
    test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
